// File: rtl/ws2812b_frame_arbiter.sv
// Frame-atomic round-robin arbiter sharing one WS2812B serializer between two pixel requesters.
// One cycle IDLE->grant latency, then combinational pass-through; led_ready is forwarded only to the owner.
module ws2812b_frame_arbiter #(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 10,
   parameter int PIX_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [23:0]      r0_data,
   input  logic             r0_valid,
   input  logic             r0_latch,
   output logic             r0_ready,
   input  logic [23:0]      r1_data,
   input  logic             r1_valid,
   input  logic             r1_latch,
   output logic             r1_ready,
   output logic [23:0]      led_data,
   output logic             led_valid,
   output logic             led_latch,
   input  logic             led_ready,
   output logic [1:0]       grant,
   output logic             abort,
   output logic [PIX_W-1:0] frame_pixels
);

   typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state, state_nxt;
   logic             last_served, last_nxt;
   logic             timeout_hit;
   logic             xfer;
   logic [CNT_W-1:0] idle_cnt;

   assign xfer = led_valid && led_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         last_served  <= 1'b1;
         idle_cnt     <= '0;
         frame_pixels <= '0;
         abort        <= 1'b0;
      end else begin
         state       <= state_nxt;
         last_served <= last_nxt;
         abort       <= timeout_hit;
         // Stalls (valid high, ready low) never advance the watchdog
         if (state == IDLE || xfer)
            idle_cnt <= '0;
         else if (!led_valid)
            idle_cnt <= idle_cnt + CNT_W'(1);
         if (state == IDLE && state_nxt != IDLE)
            frame_pixels <= '0;
         else if (xfer && frame_pixels != {PIX_W{1'b1}})
            frame_pixels <= frame_pixels + PIX_W'(1);
      end
   end

   always_comb begin
      state_nxt   = state;
      last_nxt    = last_served;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (r0_valid && (!r1_valid || last_served))
               state_nxt = G0;
            else if (r1_valid)
               state_nxt = G1;
         end
         G0, G1: begin
            if (xfer && led_latch) begin
               state_nxt = IDLE;
               last_nxt  = (state == G1);
            end else if (!led_valid && idle_cnt == TO_LAST) begin
               state_nxt   = IDLE;
               last_nxt    = (state == G1);
               timeout_hit = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      led_data  = '0;
      led_valid = 1'b0;
      led_latch = 1'b0;
      r0_ready  = 1'b0;
      r1_ready  = 1'b0;
      grant     = 2'b00;
      case (state)
         G0: begin
            led_data  = r0_data;
            led_valid = r0_valid;
            led_latch = r0_latch;
            r0_ready  = led_ready;
            grant     = 2'b01;
         end
         G1: begin
            led_data  = r1_data;
            led_valid = r1_valid;
            led_latch = r1_latch;
            r1_ready  = led_ready;
            grant     = 2'b10;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ws2812b_frame_arbiter.sv
// Bench for ws2812b_frame_arbiter: directed scenarios plus randomized traffic against a cycle model.
module tb_ws2812b_frame_arbiter;

   localparam int TO   = 8;
   localparam int CW   = 4;
   localparam int PW   = 3;
   localparam int PMAX = (1 << PW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [23:0]   r0_data = '0, r1_data = '0;
   logic          r0_valid = 1'b0, r0_latch = 1'b0;
   logic          r1_valid = 1'b0, r1_latch = 1'b0;
   logic          led_ready = 1'b0;
   logic          r0_ready, r1_ready;
   logic [23:0]   led_data;
   logic          led_valid, led_latch, abort;
   logic [1:0]    grant;
   logic [PW-1:0] frame_pixels;

   ws2812b_frame_arbiter #(.TIMEOUT(TO), .CNT_W(CW), .PIX_W(PW)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_data(r0_data), .r0_valid(r0_valid), .r0_latch(r0_latch), .r0_ready(r0_ready),
      .r1_data(r1_data), .r1_valid(r1_valid), .r1_latch(r1_latch), .r1_ready(r1_ready),
      .led_data(led_data), .led_valid(led_valid), .led_latch(led_latch), .led_ready(led_ready),
      .grant(grant), .abort(abort), .frame_pixels(frame_pixels)
   );

   always #5 clk = ~clk;

   int ncmp = 0;
   int nfail = 0;

   // Reference model: owner is -1 (nobody), 0 or 1
   int own = -1;
   int last_srv = 1;
   int idle_run = 0;
   int pix = 0;
   int ab = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_check();
      logic [31:0] g, v, l, d, rd0, rd1;
      g = 0; v = 0; l = 0; d = 0; rd0 = 0; rd1 = 0;
      if (own == 0) begin
         g = 1; v = 32'(r0_valid); l = 32'(r0_latch); d = 32'(r0_data); rd0 = 32'(led_ready);
      end else if (own == 1) begin
         g = 2; v = 32'(r1_valid); l = 32'(r1_latch); d = 32'(r1_data); rd1 = 32'(led_ready);
      end
      chk("m_grant", 32'(grant), g);
      chk("m_led_valid", 32'(led_valid), v);
      chk("m_led_latch", 32'(led_latch), l);
      chk("m_led_data", 32'(led_data), d);
      chk("m_r0_ready", 32'(r0_ready), rd0);
      chk("m_r1_ready", 32'(r1_ready), rd1);
      chk("m_abort", 32'(abort), 32'(ab));
      chk("m_frame_pixels", 32'(frame_pixels), 32'(pix));
   endtask

   task automatic model_update();
      int v, l;
      if (!rst_n) begin
         own = -1; last_srv = 1; idle_run = 0; pix = 0; ab = 0;
      end else begin
         ab = 0;
         if (own < 0) begin
            if (r0_valid && r1_valid) own = 1 - last_srv;
            else if (r0_valid) own = 0;
            else if (r1_valid) own = 1;
            if (own >= 0) begin pix = 0; idle_run = 0; end
         end else begin
            v = (own == 0) ? int'(r0_valid) : int'(r1_valid);
            l = (own == 0) ? int'(r0_latch) : int'(r1_latch);
            if (v != 0 && led_ready) begin
               if (pix < PMAX) pix++;
               idle_run = 0;
               if (l != 0) begin last_srv = own; own = -1; end
            end else if (v == 0) begin
               idle_run++;
               if (idle_run == TO) begin last_srv = own; own = -1; ab = 1; end
            end
         end
      end
   endtask

   task automatic cyc();
      #1;
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] grants[6];
      logic [1:0] prevg;
      logic a0, a1;
      int idx0, idx1, ng, p;

      // Initial reset edge (DUT state unknown before it)
      rst_n = 1'b0;
      @(posedge clk);
      model_update();
      #1;
      cyc();
      settle();
      chk("rst_grant", 32'(grant), 0);
      chk("rst_frame_pixels", 32'(frame_pixels), 0);
      chk("rst_abort", 32'(abort), 0);
      chk("rst_led_valid", 32'(led_valid), 0);
      rst_n = 1'b1;

      // Single requester, three pixels
      led_ready = 1'b1;
      r0_valid = 1'b1; r0_data = 24'h002000; r0_latch = 1'b0;
      settle();
      chk("s_idle_ready", 32'(r0_ready), 0);
      cyc();
      settle();
      chk("s_grant", 32'(grant), 1);
      chk("s_data0", 32'(led_data), 32'h002000);
      chk("s_latch0", 32'(led_latch), 0);
      cyc();
      r0_data = 24'h200000;
      settle();
      chk("s_data1", 32'(led_data), 32'h200000);
      cyc();
      r0_data = 24'h000020; r0_latch = 1'b1;
      settle();
      chk("s_latch2", 32'(led_latch), 1);
      cyc();
      r0_valid = 1'b0; r0_latch = 1'b0;
      settle();
      chk("s_idle_grant", 32'(grant), 0);
      chk("s_frame_pixels", 32'(frame_pixels), 3);
      cyc();

      // Tie after reset goes to r0; r1 waits out the whole frame
      do_reset();
      r0_valid = 1'b1; r1_valid = 1'b1; r1_data = 24'h0b0b0b;
      r0_data = 24'h100000;
      cyc();
      for (int i = 0; i < 5; i++) begin
         r0_data = 24'h100000 + 24'(i);
         r0_latch = (i == 4);
         settle();
         chk("a_grant", 32'(grant), 1);
         chk("a_r1_ready", 32'(r1_ready), 0);
         chk("a_led_data", 32'(led_data), 32'h100000 + 32'(i));
         cyc();
      end
      r0_valid = 1'b0; r0_latch = 1'b0;
      settle();
      chk("a_gap_grant", 32'(grant), 0);
      chk("a_frame_pixels", 32'(frame_pixels), 5);
      cyc();
      settle();
      chk("a_r1_grant", 32'(grant), 2);
      chk("a_r1_data", 32'(led_data), 32'h0b0b0b);
      r1_latch = 1'b1;
      cyc();
      r1_valid = 1'b0; r1_latch = 1'b0;
      cyc();

      // Downstream stall must not trip the watchdog; idle does
      r0_valid = 1'b1; r0_data = 24'h123456; led_ready = 1'b0;
      cyc();
      for (int i = 0; i < 20; i++) begin
         settle();
         chk("st_abort", 32'(abort), 0);
         chk("st_grant", 32'(grant), 1);
         chk("st_r0_ready", 32'(r0_ready), 0);
         cyc();
      end
      r0_valid = 1'b0; led_ready = 1'b1;
      for (int i = 1; i <= TO; i++) begin
         cyc();
         settle();
         chk("to_abort", 32'(abort), (i == TO) ? 1 : 0);
         chk("to_grant", 32'(grant), (i == TO) ? 0 : 1);
         chk("to_latch", 32'(led_latch), 0);
      end
      cyc();
      settle();
      chk("to_abort_clear", 32'(abort), 0);

      // Pixel counter saturation
      r0_valid = 1'b1; r0_latch = 1'b0;
      cyc();
      for (int i = 0; i < 9; i++) begin
         r0_data = 24'(i);
         r0_latch = (i == 8);
         cyc();
      end
      r0_valid = 1'b0; r0_latch = 1'b0;
      settle();
      chk("sat_frame_pixels", 32'(frame_pixels), PMAX);
      cyc();

      // Round-robin with both requesters streaming 2-pixel frames
      do_reset();
      r0_valid = 1'b1; r1_valid = 1'b1;
      idx0 = 0; idx1 = 0; ng = 0; prevg = 2'b00;
      for (int c = 0; c < 100 && ng < 6; c++) begin
         r0_latch = (idx0 == 1); r1_latch = (idx1 == 1);
         r0_data = 24'h0a0000 + 24'(idx0); r1_data = 24'h000b00 + 24'(idx1);
         settle();
         if (prevg == 2'b00 && grant != 2'b00) begin
            grants[ng] = grant;
            ng++;
         end
         prevg = grant;
         a0 = r0_ready; a1 = r1_ready;
         cyc();
         if (a0) idx0 = 1 - idx0;
         if (a1) idx1 = 1 - idx1;
      end
      chk("rr_frames", 32'(ng), 6);
      for (int i = 0; i < ng; i++)
         chk("rr_grant", 32'(grants[i]), (i % 2 == 0) ? 1 : 2);
      r0_valid = 1'b0; r1_valid = 1'b0; r0_latch = 1'b0; r1_latch = 1'b0;

      // Reset in the middle of a 4-pixel frame
      do_reset();
      r0_valid = 1'b1;
      cyc();
      cyc();
      cyc();
      settle();
      chk("mr_pixels_before", 32'(frame_pixels), 2);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      settle();
      chk("mr_grant", 32'(grant), 0);
      chk("mr_led_valid", 32'(led_valid), 0);
      chk("mr_frame_pixels", 32'(frame_pixels), 0);
      r1_valid = 1'b1;
      cyc();
      settle();
      chk("mr_tie_grant", 32'(grant), 1);
      r0_latch = 1'b1;
      cyc();
      r0_valid = 1'b0; r0_latch = 1'b0; r1_latch = 1'b1;
      cyc();
      cyc();
      r1_valid = 1'b0; r1_latch = 1'b0;
      cyc();

      // Randomized traffic against the model
      p = 50;
      for (int c = 0; c < 1500; c++) begin
         if (c % 50 == 0) p = (c % 150 == 0) ? 10 : ((c % 150 == 50) ? 50 : 90);
         rst_n     = ($urandom_range(199) != 0);
         r0_valid  = ($urandom_range(99) < p);
         r1_valid  = ($urandom_range(99) < p);
         r0_latch  = ($urandom_range(3) == 0);
         r1_latch  = ($urandom_range(3) == 0);
         r0_data   = 24'($urandom);
         r1_data   = 24'($urandom);
         led_ready = ($urandom_range(9) < 7);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
